// File: rtl/bomb_pkg.sv
// Shared types and helpers for the bomb countdown timer: state encoding,
// BCD digit widths, the M:ST time payload and digit saturation.
package bomb_pkg;

    localparam int unsigned MIN_W          = 4;
    localparam int unsigned SEC_T_W        = 3;
    localparam int unsigned SEC_O_W        = 4;
    localparam int unsigned MS_PER_SEC_DEF = 1000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_DEFUSED = 3'd3,
        ST_BOOM    = 3'd4
    } state_t;

    typedef struct packed {
        logic [MIN_W-1:0]   min;
        logic [SEC_T_W-1:0] sec_t;
        logic [SEC_O_W-1:0] sec_o;
    } bcd_time_t;

    // Clamp out-of-range digits to the largest legal BCD value of each position.
    function automatic bcd_time_t sat_time(input logic [MIN_W-1:0]   m,
                                           input logic [SEC_T_W-1:0] st,
                                           input logic [SEC_O_W-1:0] so);
        bcd_time_t t;
        t.min   = (m  > MIN_W'(9))   ? MIN_W'(9)   : m;
        t.sec_t = (st > SEC_T_W'(5)) ? SEC_T_W'(5) : st;
        t.sec_o = (so > SEC_O_W'(9)) ? SEC_O_W'(9) : so;
        return t;
    endfunction

    // True for 0:01 .. 0:10.
    function automatic logic is_low(input bcd_time_t t);
        return (t.min == '0) &&
               (((t.sec_t == '0) && (t.sec_o != '0)) ||
                ((t.sec_t == SEC_T_W'(1)) && (t.sec_o == '0)));
    endfunction

endpackage

// File: rtl/bomb_bcd_dec.sv
// Combinational M:ST decrement by 1 s, 10 s or 11 s with BCD borrow;
// results below 0:00 saturate to 0:00, and zero flags a 0:00 result.
module bomb_bcd_dec
    import bomb_pkg::*;
(
    input  bcd_time_t cur,
    input  logic      sub_one,
    input  logic      sub_ten,
    output bcd_time_t nxt,
    output logic      zero
);

    logic [SEC_O_W-1:0] so_dec;
    logic               borrow;
    logic [1:0]         tens;
    logic               underflow;

    always_comb begin
        so_dec    = cur.sec_o;
        borrow    = 1'b0;
        tens      = 2'd0;
        underflow = 1'b0;
        nxt       = cur;

        if (sub_one) begin
            if (cur.sec_o != '0) begin
                so_dec = cur.sec_o - SEC_O_W'(1);
            end else begin
                so_dec = SEC_O_W'(9);
                borrow = 1'b1;
            end
        end

        // Tens to remove: the explicit 10 s penalty plus any borrow from the ones digit.
        tens      = 2'(sub_ten) + 2'(borrow);
        nxt.sec_o = so_dec;

        if (4'(cur.sec_t) >= 4'(tens)) begin
            nxt.sec_t = cur.sec_t - SEC_T_W'(tens);
        end else if (cur.min != '0) begin
            nxt.min   = cur.min - MIN_W'(1);
            nxt.sec_t = SEC_T_W'(4'(cur.sec_t) + 4'd6 - 4'(tens));
        end else begin
            underflow = 1'b1;
        end

        if (underflow) begin
            nxt = '0;
        end

        zero = (nxt == '0);
    end

endmodule

// File: rtl/bomb_countdown.sv
// Bomb countdown timer: M:ST BCD countdown clocked by 1 ms ticks, with pause,
// defuse, load and an optional wrong-wire penalty enabled by BOMB_PENALTY_EN.
module bomb_countdown
    import bomb_pkg::*;
#(
    parameter int unsigned        MS_PER_SEC = MS_PER_SEC_DEF,
    parameter logic [MIN_W-1:0]   INIT_MIN   = 4'd5,
    parameter logic [SEC_T_W-1:0] INIT_SEC_T = 3'd0,
    parameter logic [SEC_O_W-1:0] INIT_SEC_O = 4'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ms_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               defuse,
    input  logic               strike,
    input  logic               load_en,
    input  logic [MIN_W-1:0]   load_min,
    input  logic [SEC_T_W-1:0] load_sec_t,
    input  logic [SEC_O_W-1:0] load_sec_o,
    output logic [MIN_W-1:0]   min_o,
    output logic [SEC_T_W-1:0] sec_t_o,
    output logic [SEC_O_W-1:0] sec_o_o,
    output logic               sec_pulse,
    output logic               running,
    output logic               exploded,
    output logic               defused_ok,
    output logic               low_time
);

    localparam int unsigned     MS_W      = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [MS_W-1:0] MS_LAST   = MS_W'(MS_PER_SEC - 1);
    localparam bcd_time_t       INIT_TIME = sat_time(INIT_MIN, INIT_SEC_T, INIT_SEC_O);
    localparam logic            INIT_LOW  = is_low(INIT_TIME);

    state_t          state;
    logic [MS_W-1:0] ms_cnt;
    bcd_time_t       cur;
    bcd_time_t       load_time;
    bcd_time_t       dec_time;
    logic            active;
    logic            rollover;
    logic            penalty;
    logic            dec_req;
    logic            dec_zero;

    assign load_time = sat_time(load_min, load_sec_t, load_sec_o);
    assign active    = (state == ST_RUN) || (state == ST_PAUSE);
    assign rollover  = (state == ST_RUN) && ms_tick && (ms_cnt == MS_LAST);

`ifdef BOMB_PENALTY_EN
    assign penalty = active && strike;
`else
    logic unused_strike;
    assign unused_strike = strike;
    assign penalty       = 1'b0;
`endif

    assign dec_req = rollover || penalty;

    bomb_bcd_dec u_dec (
        .cur     (cur),
        .sub_one (rollover),
        .sub_ten (penalty),
        .nxt     (dec_time),
        .zero    (dec_zero)
    );

    // Control FSM with registered flags, digits and pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ms_cnt     <= '0;
            cur        <= INIT_TIME;
            sec_pulse  <= 1'b0;
            running    <= 1'b0;
            exploded   <= 1'b0;
            defused_ok <= 1'b0;
            low_time   <= INIT_LOW;
        end else begin
            sec_pulse <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (load_en) begin
                        cur      <= load_time;
                        low_time <= is_low(load_time);
                    end else if (start && (cur != '0)) begin
                        state   <= ST_RUN;
                        ms_cnt  <= '0;
                        running <= 1'b1;
                    end
                end

                ST_RUN, ST_PAUSE: begin
                    if (defuse) begin
                        state      <= ST_DEFUSED;
                        running    <= 1'b0;
                        defused_ok <= 1'b1;
                    end else begin
                        if ((state == ST_RUN) && ms_tick) begin
                            ms_cnt <= rollover ? '0 : ms_cnt + MS_W'(1);
                        end
                        if (dec_req) begin
                            cur       <= dec_time;
                            low_time  <= is_low(dec_time);
                            sec_pulse <= rollover;
                        end
                        // Reaching 0:00 wins over a same-cycle pause toggle.
                        if (dec_req && dec_zero) begin
                            state    <= ST_BOOM;
                            running  <= 1'b0;
                            exploded <= 1'b1;
                        end else if (pause) begin
                            state <= (state == ST_RUN) ? ST_PAUSE : ST_RUN;
                        end
                    end
                end

                default: begin
                    if (load_en) begin
                        state      <= ST_IDLE;
                        cur        <= load_time;
                        low_time   <= is_low(load_time);
                        exploded   <= 1'b0;
                        defused_ok <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign min_o   = cur.min;
    assign sec_t_o = cur.sec_t;
    assign sec_o_o = cur.sec_o;

endmodule

// File: tb/tb_bomb_countdown.sv
// Directed scoreboard bench for bomb_countdown with MS_PER_SEC=4; strike
// expectations follow BOMB_PENALTY_EN when it is defined for the build.
module tb_bomb_countdown;

    localparam logic [5:0] C_NONE = 6'h00;
    localparam logic [5:0] C_TICK = 6'h01;
    localparam logic [5:0] C_STRT = 6'h02;
    localparam logic [5:0] C_PAUS = 6'h04;
    localparam logic [5:0] C_DEFU = 6'h08;
    localparam logic [5:0] C_STRK = 6'h10;
    localparam logic [5:0] C_LOAD = 6'h20;
    localparam logic [15:0] ALL   = 16'hFFFF;
    localparam logic [15:0] NO_SP = 16'hFFEF;

    logic       clk = 1'b0;
    logic       rst;
    logic       ms_tick, start, pause, defuse, strike, load_en;
    logic [3:0] load_min;
    logic [2:0] load_sec_t;
    logic [3:0] load_sec_o;
    logic [3:0] min_o;
    logic [2:0] sec_t_o;
    logic [3:0] sec_o_o;
    logic       sec_pulse, running, exploded, defused_ok, low_time;

    typedef struct {
        string       tag;
        logic [15:0] exp;
        logic [15:0] care;
    } sb_t;

    sb_t         sb_q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    bomb_countdown #(.MS_PER_SEC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ms_tick    (ms_tick),
        .start      (start),
        .pause      (pause),
        .defuse     (defuse),
        .strike     (strike),
        .load_en    (load_en),
        .load_min   (load_min),
        .load_sec_t (load_sec_t),
        .load_sec_o (load_sec_o),
        .min_o      (min_o),
        .sec_t_o    (sec_t_o),
        .sec_o_o    (sec_o_o),
        .sec_pulse  (sec_pulse),
        .running    (running),
        .exploded   (exploded),
        .defused_ok (defused_ok),
        .low_time   (low_time)
    );

    always #5 clk = ~clk;

    // {min, sec_t, sec_o, sec_pulse, running, exploded, defused_ok, low_time}
    function automatic logic [15:0] pk(input int m, input int st, input int so,
                                       input bit sp, input bit r, input bit e,
                                       input bit d, input bit l);
        return {4'(m), 3'(st), 4'(so), sp, r, e, d, l};
    endfunction

    task automatic expect_v(input string tag, input logic [15:0] exp,
                            input logic [15:0] care = ALL);
        sb_t e;
        e.tag  = tag;
        e.exp  = exp;
        e.care = care;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t         e;
        logic [15:0] obs;
        obs = {min_o, sec_t_o, sec_o_o, sec_pulse, running, exploded, defused_ok, low_time};
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            assert ((obs & e.care) === (e.exp & e.care)) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs & e.care, e.exp & e.care);
            end
        end
    endtask

    // Drive one cycle of pulses, sample just after the edge, check queued expectations.
    task automatic step(input logic [5:0] ctl, input logic [3:0] lm = 4'd0,
                        input logic [2:0] lst = 3'd0, input logic [3:0] lso = 4'd0);
        ms_tick    = ctl[0];
        start      = ctl[1];
        pause      = ctl[2];
        defuse     = ctl[3];
        strike     = ctl[4];
        load_en    = ctl[5];
        load_min   = lm;
        load_sec_t = lst;
        load_sec_o = lso;
        @(posedge clk);
        #1;
        ms_tick = 1'b0; start = 1'b0; pause = 1'b0;
        defuse  = 1'b0; strike = 1'b0; load_en = 1'b0;
        drain();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(C_TICK);
    endtask

    initial begin
        rst = 1'b1;
        ms_tick = 1'b0; start = 1'b0; pause = 1'b0;
        defuse  = 1'b0; strike = 1'b0; load_en = 1'b0;
        load_min = 4'd0; load_sec_t = 3'd0; load_sec_o = 4'd0;
        #2 rst = 1'b0;
        #10;
        expect_v("reset", pk(5, 0, 0, 0, 0, 0, 0, 0));
        drain();
        rst = 1'b1;

        // 0:02 counts out to BOOM
        expect_v("load_0_02", pk(0, 0, 2, 0, 0, 0, 0, 1));
        step(C_LOAD, 4'd0, 3'd0, 4'd2);
        expect_v("start_0_02", pk(0, 0, 2, 0, 1, 0, 0, 1));
        step(C_STRT);
        for (int i = 1; i <= 8; i++) begin
            expect_v($sformatf("boom_tick%0d", i),
                     pk(0, 0, (i < 4) ? 2 : ((i < 8) ? 1 : 0),
                        (i == 4) || (i == 8), i < 8, i == 8, 1'b0, i < 8));
            step(C_TICK);
        end
        expect_v("boom_terminal", pk(0, 0, 0, 0, 0, 1, 0, 0));
        step(C_TICK | C_STRT | C_PAUS | C_DEFU | C_STRK);

        // minute borrow
        expect_v("load_1_00", pk(1, 0, 0, 0, 0, 0, 0, 0));
        step(C_LOAD, 4'd1, 3'd0, 4'd0);
        expect_v("start_1_00", pk(1, 0, 0, 0, 1, 0, 0, 0));
        step(C_STRT);
        ticks(3);
        expect_v("minute_borrow", pk(0, 5, 9, 1, 1, 0, 0, 0));
        step(C_TICK);
        expect_v("load_in_run_ignored", pk(0, 5, 9, 0, 1, 0, 0, 0));
        step(C_LOAD, 4'd0, 3'd0, 4'd5);
        expect_v("defuse_run", pk(0, 5, 9, 0, 0, 0, 1, 0));
        step(C_DEFU);

        // pause freezes digits and ms count
        expect_v("load_0_05", pk(0, 0, 5, 0, 0, 0, 0, 1));
        step(C_LOAD, 4'd0, 3'd0, 4'd5);
        step(C_STRT);
        ticks(2);
        step(C_PAUS);
        ticks(9);
        expect_v("paused_hold", pk(0, 0, 5, 0, 1, 0, 0, 1));
        step(C_TICK);
        step(C_PAUS);
        ticks(1);
        expect_v("resume_rollover", pk(0, 0, 4, 1, 1, 0, 0, 1));
        step(C_TICK);

        // defuse beats a same-cycle rollover
        step(C_DEFU);
        step(C_LOAD, 4'd0, 3'd0, 4'd3);
        step(C_STRT);
        ticks(3);
        expect_v("defuse_beats_tick", pk(0, 0, 3, 0, 0, 0, 1, 1));
        step(C_TICK | C_DEFU);
        expect_v("defused_no_pulse", pk(0, 0, 3, 0, 0, 0, 1, 1));
        step(C_NONE);

        // strikes
        step(C_LOAD, 4'd0, 3'd1, 4'd5);
        step(C_STRT);
`ifdef BOMB_PENALTY_EN
        expect_v("strike1", pk(0, 0, 5, 0, 1, 0, 0, 1), NO_SP);
        step(C_STRK);
        expect_v("strike2", pk(0, 0, 0, 0, 0, 1, 0, 0), NO_SP);
        step(C_STRK);
`else
        expect_v("strike1", pk(0, 1, 5, 0, 1, 0, 0, 0));
        step(C_STRK);
        expect_v("strike2", pk(0, 1, 5, 0, 1, 0, 0, 0));
        step(C_STRK);
`endif
        step(C_DEFU);
        step(C_LOAD, 4'd0, 3'd1, 4'd5);
        step(C_STRT);
        ticks(3);
`ifdef BOMB_PENALTY_EN
        expect_v("strike_rollover", pk(0, 0, 4, 1, 1, 0, 0, 1));
`else
        expect_v("strike_rollover", pk(0, 1, 4, 1, 1, 0, 0, 0));
`endif
        step(C_TICK | C_STRK);
        step(C_DEFU);

        // load saturation and start at zero
        expect_v("load_saturate", pk(9, 5, 9, 0, 0, 0, 0, 0));
        step(C_LOAD, 4'd12, 3'd7, 4'd15);
        step(C_LOAD, 4'd0, 3'd0, 4'd0);
        expect_v("start_at_zero", pk(0, 0, 0, 0, 0, 0, 0, 0));
        step(C_STRT);

        // asynchronous reset mid-run
        step(C_LOAD, 4'd2, 3'd3, 4'd0);
        expect_v("run_2_30", pk(2, 3, 0, 0, 1, 0, 0, 0));
        step(C_STRT);
        ticks(2);
        #2 rst = 1'b0;
        #1;
        expect_v("async_reset", pk(5, 0, 0, 0, 0, 0, 0, 0));
        drain();
        #2 rst = 1'b1;
        expect_v("post_reset_idle", pk(5, 0, 0, 0, 0, 0, 0, 0));
        step(C_NONE);
        expect_v("post_reset_start", pk(5, 0, 0, 0, 1, 0, 0, 0));
        step(C_STRT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bomb_countdown.md
BOMB_COUNTDOWN -- requirements
Module: bomb_countdown

Interface
REQ-001 Parameter MS_PER_SEC, default 1000, number of ms_tick pulses per counted second.
REQ-002 Parameter INIT_MIN, default 4'd5, minutes digit loaded at reset.
REQ-003 Parameter INIT_SEC_T, default 3'd0, seconds-tens digit loaded at reset.
REQ-004 Parameter INIT_SEC_O, default 4'd0, seconds-ones digit loaded at reset.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 ms_tick  input  1  one-cycle 1 ms timeout pulse from the LFSR ms timer.
REQ-008 start  input  1  one-cycle pulse; arms countdown.
REQ-009 pause  input  1  one-cycle pulse; toggles RUN/PAUSE.
REQ-010 defuse  input  1  one-cycle pulse; correct wire cut.
REQ-011 strike  input  1  one-cycle pulse; wrong wire cut (penalty feature only).
REQ-012 load_en  input  1  one-cycle pulse; load digits from load_* ports.
REQ-013 load_min / load_sec_t / load_sec_o  input  4/3/4  BCD digits to load.
REQ-014 min_o / sec_t_o / sec_o_o  output  4/3/4  remaining time, BCD, M:ST.
REQ-015 sec_pulse  output  1  one-cycle pulse on each decrement.
REQ-016 running / exploded / defused_ok  output  1  state flags; at most one high.
REQ-017 low_time  output  1  high when remaining time <= 0:10 and nonzero.

Function
REQ-018 States IDLE, RUN, PAUSE, DEFUSED, BOOM; running=RUN|PAUSE, exploded=BOOM, defused_ok=DEFUSED.
REQ-019 Loaded digits above range saturate: min 9, sec_t 5, sec_o 9.
REQ-020 IDLE: load_en loads digits; start with time nonzero -> RUN, ms_cnt<=0; start at 0:00 ignored.
REQ-021 RUN: ms_tick increments ms_cnt (width clog2(MS_PER_SEC)); at ms_cnt==MS_PER_SEC-1 with ms_tick: ms_cnt<=0, time decrements by 1 s with BCD borrow, sec_pulse=1 next cycle.
REQ-022 Decrement reaching 0:00 -> BOOM on the same edge; digits stay 0:00.
REQ-023 RUN: pause -> PAUSE, ms_cnt and digits frozen; PAUSE: pause -> RUN, ms_cnt resumes from held value; ms_tick ignored in PAUSE.
REQ-024 defuse in RUN or PAUSE -> DEFUSED, digits frozen; defuse has priority over ms_tick, strike and pause in the same cycle.
REQ-025 DEFUSED and BOOM are terminal; only load_en exits (-> IDLE with loaded digits); start, pause, defuse, strike, ms_tick ignored.
REQ-026 load_en ignored in RUN and PAUSE.
REQ-027 Simultaneous strike and second-rollover in RUN: combined 11 s subtraction, saturating at 0:00 -> BOOM.
REQ-028 sec_pulse is registered, one cycle wide, never asserted outside RUN transitions.

Reset
REQ-029 rst low: state IDLE, ms_cnt 0, digits INIT_MIN:INIT_SEC_T INIT_SEC_O, sec_pulse/running/exploded/defused_ok 0; low_time per REQ-017.
REQ-030 Reset asserted mid-RUN returns to IDLE immediately, asynchronously; release resumes normal operation on next rising edge.

Configuration
REQ-031 Macro BOMB_PENALTY_EN defined: strike in RUN or PAUSE subtracts 10 s (BCD, with borrow); remaining < 10 s -> digits 0:00, BOOM.
REQ-032 Macro BOMB_PENALTY_EN undefined: strike port present but ignored; REQ-027 reduces to 1 s.

Structure
REQ-033 Package bomb_pkg holds state encoding constants, BCD digit widths, and MS_PER_SEC default.
REQ-034 Sub-module bomb_bcd_dec: combinational M:ST decrement by 1 s or 10 s or 11 s with borrow, saturation to 0:00 and zero flag.

Verification (bench uses MS_PER_SEC=4)
REQ-035 Load 0:02, start, 8 ms_ticks -> sec_pulse twice, digits 0:01 then 0:00, exploded=1 after 8th tick.
REQ-036 Load 1:00, start, 4 ticks -> 0:59 (minute borrow); low_time=0.
REQ-037 Load 0:05, start, 2 ticks, pause, 10 ticks, pause, 2 ticks -> 0:04, running=1.
REQ-038 Load 0:03, start, defuse in same cycle as 4th tick -> defused_ok=1, digits 0:03, no sec_pulse.
REQ-039 PENALTY_EN: load 0:15, start, strike -> 0:05, low_time=1; second strike -> 0:00, exploded=1; without macro both strikes leave 0:15.
REQ-040 Assert rst mid-RUN at 2:30 -> IDLE, digits INIT values, flags 0, within same cycle.
